// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART transmitter and receiver.
//   tx_state_t  : transmitter FSM state encoding
//   DATA_BITS   : payload bits per frame
//   uart_byte_t : one payload byte
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned BIT_CNT_W = $clog2(DATA_BITS);

    typedef logic [DATA_BITS-1:0] uart_byte_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter. Counts 0..CLOCKS_PER_PULSE-1 and wraps.
//   clk   : system clock
//   rst   : synchronous, active-high reset
//   clear : hold the count at 0 (used while the line is idle)
//   tick  : high while the count equals CLOCKS_PER_PULSE-1 (last cycle of a bit)
module uart_baud_cnt #(
    parameter int unsigned CLOCKS_PER_PULSE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLOCKS_PER_PULSE - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // Next count: wrap at the end of a bit, or hold at zero when cleared.
    always_comb begin
        cnt_next = cnt + CNT_W'(1);
        if (clear || (cnt == LAST)) begin
            cnt_next = '0;
        end
    end

    // tick is registered from the next count so it lines up with cnt == LAST.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt_next;
            tick <= (cnt_next == LAST);
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8-bit UART transmitter, LSB first, idle-high line, 8N1 by default.
// Optional parity bit enabled by defining the macro UART_PARITY_EN.
//   clk      : system clock
//   rst      : synchronous, active-high reset
//   tx_data  : byte to send, taken when tx_valid && tx_ready
//   tx_valid : tx_data is valid
//   tx_ready : one-entry holding register is empty
//   tx       : serial line (registered)
//   busy     : frame in flight or holding register full
//   done     : one-cycle pulse on the last cycle of each stop bit
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_PULSE = 16,
    parameter bit          PARITY_ODD       = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    if (CLOCKS_PER_PULSE < 2) begin : g_cpp_check
        $error("uart_transmitter: CLOCKS_PER_PULSE must be >= 2");
    end

    tx_state_t                state;
    tx_state_t                state_next;
    uart_byte_t               hold;
    uart_byte_t               shift_reg;
    logic                     hold_valid;
    logic                     hold_next;
    logic [BIT_CNT_W-1:0]     bit_cnt;
    logic                     accept;
    logic                     load;
    logic                     tick;
    logic                     clear;
    logic                     tx_next;
    logic                     done_next;
`ifdef UART_PARITY_EN
    logic                     parity_bit;
`else
    localparam bit unused_parity_odd = PARITY_ODD;
`endif

    // Bit timing; held at zero while idle so START always gets a full bit.
    assign clear = (state == IDLE);

    uart_baud_cnt #(
        .CLOCKS_PER_PULSE(CLOCKS_PER_PULSE)
    ) u_baud_cnt (
        .clk  (clk),
        .rst  (rst),
        .clear(clear),
        .tick (tick)
    );

    // Accept only ever happens with hold empty, load only with hold full: never together.
    assign accept    = tx_valid && tx_ready;
    assign hold_next = accept ? 1'b1 : (load ? 1'b0 : hold_valid);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; load pulls the holding register into the shifter.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (hold_valid) begin
                    state_next = START;
                    load       = 1'b1;
                end
            end
            START: begin
                if (tick) state_next = DATA;
            end
            DATA: begin
                if (tick && (bit_cnt == BIT_CNT_W'(DATA_BITS - 1))) begin
`ifdef UART_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (tick) state_next = STOP;
            end
`endif
            STOP: begin
                if (tick) begin
                    if (hold_valid) begin
                        // Gapless: next frame's start bit follows this stop bit directly.
                        state_next = START;
                        load       = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode; registered below so tx lags state by one cycle.
    always_comb begin
        tx_next   = 1'b1;
        done_next = 1'b0;
        case (state)
            START: tx_next = 1'b0;
            DATA:  tx_next = shift_reg[0];
`ifdef UART_PARITY_EN
            PARITY: tx_next = parity_bit;
`endif
            STOP: begin
                tx_next   = 1'b1;
                done_next = tick;
            end
            default: tx_next = 1'b1;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold       <= '0;
            hold_valid <= 1'b0;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            tx         <= 1'b1;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef UART_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            hold_valid <= hold_next;
            tx_ready   <= !hold_next;
            busy       <= (state_next != IDLE) || hold_next;
            tx         <= tx_next;
            done       <= done_next;
            if (accept) begin
                hold <= tx_data;
            end
            if (load) begin
                shift_reg  <= hold;
                bit_cnt    <= '0;
`ifdef UART_PARITY_EN
                parity_bit <= (^hold) ^ PARITY_ODD;
`endif
            end else if ((state == DATA) && tick) begin
                shift_reg <= shift_reg >> 1;
                bit_cnt   <= bit_cnt + BIT_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter (CLOCKS_PER_PULSE = 16).
module tb_uart_transmitter;

    localparam int CPP           = 16;
    localparam bit TB_PARITY_ODD = 1'b0;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx;
    logic       busy;
    logic       done;

    int tests    = 0;
    int fails    = 0;
    int acc_cnt  = 0;
    int done_cnt = 0;

    // Frame bits in line order: bit 0 = start, then data LSB first, [parity], stop.
    typedef struct {
        logic [7:0]  data;
        logic [10:0] bits;
    } vec_t;

    vec_t vecs[4];

    uart_transmitter #(
        .CLOCKS_PER_PULSE(CPP),
        .PARITY_ODD      (TB_PARITY_ODD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && tx_valid && tx_ready) acc_cnt <= acc_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected frame for the hand-written sequences.
    function automatic logic [10:0] mk_frame(input logic [7:0] d);
`ifdef UART_PARITY_EN
        logic p;
        p = (^d) ^ TB_PARITY_ODD;
        return {1'b1, p, d, 1'b0};
`else
        return {1'b0, 1'b1, d, 1'b0};
`endif
    endfunction

    // Present a byte and wait (bounded) for the accept edge; returns #1 after it.
    task automatic send(input logic [7:0] d, input bit keep);
        int n;
        n = 0;
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: tx_ready never rose for byte %0h", d);
            tx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (!keep) tx_valid = 1'b0;
    endtask

    // Walk a whole frame cycle by cycle; prewait skips the load edge after accept.
    task automatic check_frame(input string name, input logic [10:0] bits,
                               input bit prewait, input bit more);
        int   fl;
        int   bad_tx;
        int   bad_done;
        int   bad_busy;
        logic exp_tx;
        fl       = NB * CPP;
        bad_tx   = 0;
        bad_done = 0;
        bad_busy = 0;
        if (prewait) begin
            @(posedge clk);
            #1;
        end
        for (int c = 0; c < fl; c++) begin
            @(posedge clk);
            #1;
            exp_tx = bits[c / CPP];
            if (tx !== exp_tx) bad_tx++;
            if (done !== (c == fl - 1)) bad_done++;
            if (busy !== ((c != fl - 1) || more)) bad_busy++;
        end
        check({name, "_tx_bad_cycles"},   bad_tx,   0);
        check({name, "_done_bad_cycles"}, bad_done, 0);
        check({name, "_busy_bad_cycles"}, bad_busy, 0);
    endtask

    initial begin
        int acc0;
        int done0;
        int bad;

`ifdef UART_PARITY_EN
        if (TB_PARITY_ODD) begin
            vecs[0] = '{8'hA5, 11'h74A};
            vecs[1] = '{8'h55, 11'h6AA};
            vecs[2] = '{8'h07, 11'h40E};
            vecs[3] = '{8'h81, 11'h702};
        end else begin
            vecs[0] = '{8'hA5, 11'h54A};
            vecs[1] = '{8'h55, 11'h4AA};
            vecs[2] = '{8'h07, 11'h60E};
            vecs[3] = '{8'h81, 11'h502};
        end
`else
        vecs[0] = '{8'hA5, 11'h34A};
        vecs[1] = '{8'h55, 11'h2AA};
        vecs[2] = '{8'h07, 11'h20E};
        vecs[3] = '{8'h81, 11'h302};
`endif

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx",       tx,       1);
        check("reset_tx_ready", tx_ready, 1);
        check("reset_busy",     busy,     0);
        check("reset_done",     done,     0);
        rst = 1'b0;

        // Idle for 500 cycles with tx_data wiggling and tx_valid low.
        acc0 = acc_cnt;
        bad  = 0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #1;
            tx_data = 8'($urandom);
            if (tx !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1) bad++;
        end
        check("idle_bad_cycles", bad, 0);
        check("idle_accepts", acc_cnt - acc0, 0);

        // Single frames from the table.
        for (int i = 0; i < 4; i++) begin
            send(vecs[i].data, 1'b0);
            check($sformatf("vec%0d_ready_low", i), tx_ready, 0);
            check_frame($sformatf("vec%0d", i), vecs[i].bits, 1'b1, 1'b0);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_idle_after", i), {tx, busy, tx_ready, done}, 4'b1010);
            repeat (10) @(posedge clk);
        end

        // Back-to-back 0x00 then 0xFF, gapless.
        done0 = done_cnt;
        send(8'h00, 1'b0);
        check("b2b_ready_low_before_pull", tx_ready, 0);
        fork
            begin
                check_frame("b2b_first",  mk_frame(8'h00), 1'b1, 1'b1);
                check_frame("b2b_second", mk_frame(8'hFF), 1'b0, 1'b0);
            end
            send(8'hFF, 1'b0);
        join
        @(posedge clk);
        #1;
        check("b2b_done_pulses", done_cnt - done0, 2);
        repeat (10) @(posedge clk);

        // tx_valid held high: second byte only taken once tx_ready rises.
        acc0 = acc_cnt;
        send(8'h12, 1'b1);
        tx_data = 8'h34;
        check("hold_ready_low", tx_ready, 0);
        fork
            begin
                check_frame("hold_first",  mk_frame(8'h12), 1'b1, 1'b1);
                check_frame("hold_second", mk_frame(8'h34), 1'b0, 1'b0);
            end
            send(8'h34, 1'b0);
        join
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("hold_no_third_frame", bad, 0);
        check("hold_accepts", acc_cnt - acc0, 2);

        // Reset in DATA bit 3 of 0x3C with 0x81 pending.
        send(8'h3C, 1'b0);
        send(8'h81, 1'b0);
        repeat (70) begin
            @(posedge clk);
            #1;
        end
        check("rst_mid_bit3_value", tx, 1);
        check("rst_mid_pending", tx_ready, 0);
        done0 = done_cnt;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_outputs", {tx, busy, tx_ready, done}, 4'b1010);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1) bad++;
        end
        check("rst_pending_discarded", bad, 0);
        check("rst_no_done", done_cnt - done0, 0);
        send(8'h55, 1'b0);
        check_frame("after_rst_55", mk_frame(8'h55), 1'b1, 1'b0);
        repeat (5) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
